dcache_ctrl: RTL
================

// Module: dcache_ctrl
// PURPOSE
//  Direct-mapped, write-back, write-allocate L1 data cache; the responder for the pipeline's MEM-stage load/store port.
//  On a hit it answers in the same cycle. On a miss it stalls the pipeline and fetches the line from off-chip memory.
//  Sits between the EX/MEM register outputs and an off-chip memory with a req/ack handshake and 256-bit lines.
// PARAMETERS
//  ADDR_W     32   byte address width (CPU and memory side)
//  WORD_W     32   CPU data word width
//  LINE_W     256  line width in bits (8 words)
//  NUM_LINES  32   number of cache lines; addr = {tag[31:10], index[9:5], offset[4:0]}
// PORTS
//  clk_i        in   1        clock
//  rst_i        in   1        reset, asynchronous, active-low
//  cpu_req_i    in   1        MEM stage access valid (MemRead | MemWrite)
//  cpu_we_i     in   1        1 = store, 0 = load
//  cpu_addr_i   in   ADDR_W   byte address; bits [1:0] ignored
//  cpu_wdata_i  in   WORD_W   store data
//  cpu_rdata_o  out  WORD_W   load data; valid when cpu_req_i & ~cpu_stall_o
//  cpu_stall_o  out  1        freezes PC, IF/ID, ID/EX, EX/MEM, MEM/WB
//  mem_req_o    out  1        off-chip request
//  mem_we_o     out  1        1 = line write-back, 0 = line fetch
//  mem_addr_o   out  ADDR_W   line-aligned address, [4:0] = 0
//  mem_wdata_o  out  LINE_W   victim line on write-back
//  mem_rdata_i  in   LINE_W   fetched line; sampled when mem_ack_i & ~mem_we_o
//  mem_ack_i    in   1        one-cycle completion pulse for the current mem_req_o
// BEHAVIOUR
//  Reset (rst_i=0, async): state=IDLE; all valid and dirty bits = 0; mem_req_o=0, mem_we_o=0; mem_addr_o=0; mem_wdata_o=0.
//   cpu_stall_o=0 and cpu_rdata_o=0 because no hit exists. Reset mid-transaction aborts it; the fill is discarded.
//  hit = valid[idx] & (tag[idx] == addr[31:10]). Combinational, same cycle as the request.
//  cpu_stall_o = cpu_req_i & (~hit | state != IDLE). Combinational.
//  cpu_rdata_o = word addr[4:2] of line[idx] when cpu_req_i & hit, else 0.
//  Load hit: 0 stall cycles.
//  Store hit: word addr[4:2] is written and dirty[idx] is set at the clock edge. 0 stall cycles.
//  FSM states: IDLE, WRITEBACK, ALLOCATE, FILL.
//   IDLE: on cpu_req_i & ~hit -> WRITEBACK if valid[idx] & dirty[idx], else -> ALLOCATE.
//   WRITEBACK: mem_req_o=1, mem_we_o=1, mem_addr_o={tag[idx], idx, 5'b0}, mem_wdata_o=line[idx].
//    Outputs are held stable until mem_ack_i, then -> ALLOCATE.
//   ALLOCATE: mem_req_o=1, mem_we_o=0, mem_addr_o={addr[31:10], idx, 5'b0}.
//    On mem_ack_i: line[idx]=mem_rdata_i, tag updated, valid=1, dirty=0; -> FILL.
//   FILL: mem_req_o=0; stall held for 1 cycle; -> IDLE.
//    The access replays as a hit; a store then sets dirty.
//  mem_req_o is a registered output. It deasserts in the cycle after ack.
//  mem_ack_i may arrive in the first cycle mem_req_o is high. mem_ack_i while mem_req_o=0 is ignored.
//  Miss latency, clean victim: 1 (IDLE) + ALLOCATE cycles + 1 (FILL).
//  Miss latency, dirty victim: the same, plus the WRITEBACK cycles.
//  While cpu_stall_o=1 the CPU holds req/we/addr/wdata stable. A change is a protocol error and is not handled.
//  cpu_req_i=0 in IDLE: no state change and no memory traffic.
// CONFIGURATION
//  DCACHE_STATS_EN defined: adds outputs hit_cnt_o[31:0], miss_cnt_o[31:0] and wb_cnt_o[31:0].
//   Counting is one per IDLE-state evaluation: hit_cnt_o on cpu_req_i & hit & ~stall; miss_cnt_o on IDLE->miss;
//   wb_cnt_o on entry to WRITEBACK.
//   The counters saturate at 32'hFFFF_FFFF and are cleared by reset.
//  DCACHE_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  dcache_pkg holds:
//   - field widths TAG_W=22, IDX_W=5, OFF_W=5;
//   - the state enum (IDLE/WRITEBACK/ALLOCATE/FILL);
//   - field-extract functions for tag, index and word select.
//  Sub-module dcache_sram: NUM_LINES x {valid, dirty, tag, line} storage with async read;
//   synchronous full-line write or single-word write; async clear of valid/dirty.
//  dcache_ctrl holds the FSM, hit logic, memory-side registers and the optional counters.
// TESTING
//  1. Cold load of 0x0000_0040, memory model ack after 3 cycles.
//     -> stall 5 cycles; one fetch at 0x40; rdata = memory word; then hit with 0 stall.
//  2. Store 0xDEAD_BEEF to 0x44 (hit), then load 0x44.
//     -> no stall; rdata = 0xDEADBEEF; no memory traffic.
//  3. Load 0x0000_0444, same index 2 as the dirty line 0x40, different tag.
//     -> write-back at 0x40 with word1 = 0xDEADBEEF, then fetch at 0x440.
//  4. Store miss to 0x80.
//     -> fetch at 0x80 only, no write-back; line dirty afterwards; word0 equals the stored value.
//  5. Assert rst_i=0 during ALLOCATE, then release and repeat scenario 1.
//     -> mem_req_o=0 immediately and stall=0; all lines miss again.
//  6. Memory acks in the same cycle mem_req_o rises.
//     -> clean-victim miss completes with 3 stall cycles; with DCACHE_STATS_EN, hit/miss/wb counts match the scoreboard.

Source files
------------

// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the direct-mapped L1 data cache (dcache_ctrl and
// dcache_sram): geometry, address field widths, controller state encoding and
// helpers that split a byte address into tag / index / word-select fields.
// Address layout: {tag[31:10], index[9:5], offset[4:0]}; offset[1:0] is the
// byte lane and is not used by the word-granular cache.
// -----------------------------------------------------------------------------
package dcache_pkg;

    localparam int ADDR_W    = 32;
    localparam int WORD_W    = 32;
    localparam int LINE_W    = 256;
    localparam int NUM_LINES = 32;

    localparam int TAG_W  = 22;
    localparam int IDX_W  = 5;
    localparam int OFF_W  = 5;
    localparam int WSEL_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        FILL
    } state_e;

    // Shift-and-truncate so every address bit is consumed by the helper.
    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return TAG_W'(a >> (IDX_W + OFF_W));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a >> OFF_W);
    endfunction

    function automatic logic [WSEL_W-1:0] addr_wsel(input logic [ADDR_W-1:0] a);
        return WSEL_W'(a >> 2);
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// -----------------------------------------------------------------------------
// dcache_sram
// NUM_LINES x {valid, dirty, tag, line} storage for the data cache.
//   clk_i, rst_i   clock, asynchronous active-low reset (clears valid/dirty)
//   idx_i          line index for the asynchronous read and for both writes
//   rd_*_o         asynchronous read of the indexed entry
//   fill_en_i      full-line write: tag/line loaded, valid=1, dirty=0
//   word_we_i      single-word write at word_sel_i, sets dirty
// Tag and line arrays have no reset; valid=0 makes their content irrelevant.
// -----------------------------------------------------------------------------
module dcache_sram
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic              rd_valid_o,
    output logic              rd_dirty_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [LINE_W-1:0] rd_line_o,
    input  logic              fill_en_i,
    input  logic [TAG_W-1:0]  fill_tag_i,
    input  logic [LINE_W-1:0] fill_line_i,
    input  logic              word_we_i,
    input  logic [WSEL_W-1:0] word_sel_i,
    input  logic [WORD_W-1:0] word_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    line_q [NUM_LINES];

    assign rd_valid_o = valid_q[idx_i];
    assign rd_dirty_o = dirty_q[idx_i];
    assign rd_tag_o   = tag_q[idx_i];
    assign rd_line_o  = line_q[idx_i];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_en_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            line_q[idx_i] <= fill_line_i;
        end else if (word_we_i) begin
            line_q[idx_i][int'(word_sel_i)*WORD_W +: WORD_W] <= word_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
// Direct-mapped, write-back, write-allocate L1 data cache serving the MEM
// stage. Hits answer combinationally in the request cycle; misses stall the
// pipeline while the victim is written back (if dirty) and the line fetched.
//   clk_i, rst_i         clock, asynchronous active-low reset
//   cpu_req_i/we_i       access valid / store
//   cpu_addr_i/wdata_i   byte address / store data
//   cpu_rdata_o          load data (valid when cpu_req_i & ~cpu_stall_o)
//   cpu_stall_o          pipeline freeze
//   mem_req_o/we_o       registered line request / write-back
//   mem_addr_o/wdata_o   line-aligned address / victim line
//   mem_rdata_i/ack_i    fetched line / one-cycle completion pulse
// Optional macro DCACHE_STATS_EN adds saturating hit_cnt_o, miss_cnt_o and
// wb_cnt_o counters.
// -----------------------------------------------------------------------------
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [WORD_W-1:0] cpu_wdata_i,
    output logic [WORD_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
   ,output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o,
    output logic [31:0]       wb_cnt_o
`endif
);

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WSEL_W-1:0] req_wsel;

    logic              rd_valid, rd_dirty;
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_W-1:0] rd_line;

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

    logic hit, ack_v, fill_en, word_we;

    assign req_tag  = addr_tag(cpu_addr_i);
    assign req_idx  = addr_idx(cpu_addr_i);
    assign req_wsel = addr_wsel(cpu_addr_i);

    dcache_sram u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (req_idx),
        .rd_valid_o  (rd_valid),
        .rd_dirty_o  (rd_dirty),
        .rd_tag_o    (rd_tag),
        .rd_line_o   (rd_line),
        .fill_en_i   (fill_en),
        .fill_tag_i  (req_tag),
        .fill_line_i (mem_rdata_i),
        .word_we_i   (word_we),
        .word_sel_i  (req_wsel),
        .word_i      (cpu_wdata_i)
    );

    assign hit = rd_valid & (rd_tag == req_tag);

    // A core held in reset is never frozen by the cache.
    assign cpu_stall_o = rst_i & cpu_req_i & (~hit | (state_q != IDLE));
    assign cpu_rdata_o = (cpu_req_i & hit) ? rd_line[int'(req_wsel)*WORD_W +: WORD_W] : '0;

    // Stores only commit on the unstalled IDLE cycle, which is also the replay
    // cycle after a fill, so a store miss dirties the freshly fetched line.
    assign word_we = cpu_req_i & cpu_we_i & hit & (state_q == IDLE);

    // An ack is only meaningful while a request is outstanding.
    assign ack_v = mem_ack_i & mem_req_q;

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req_i && !hit) begin
                    mem_req_d = 1'b1;
                    if (rd_valid && rd_dirty) begin
                        state_d     = WRITEBACK;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {rd_tag, req_idx, {OFF_W{1'b0}}};
                        mem_wdata_d = rd_line;
                    end else begin
                        state_d    = ALLOCATE;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {req_tag, req_idx, {OFF_W{1'b0}}};
                    end
                end
            end
            WRITEBACK: begin
                // The fetch follows back-to-back; the we/addr change marks the
                // start of the new request.
                if (ack_v) begin
                    state_d    = ALLOCATE;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {req_tag, req_idx, {OFF_W{1'b0}}};
                end
            end
            ALLOCATE: begin
                if (ack_v) begin
                    state_d   = FILL;
                    fill_en   = 1'b1;
                    mem_req_d = 1'b0;
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
    logic        idle_eval;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign idle_eval = cpu_req_i & (state_q == IDLE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            if (idle_eval && hit)
                hit_cnt_q <= sat_inc(hit_cnt_q);
            if (idle_eval && !hit)
                miss_cnt_q <= sat_inc(miss_cnt_q);
            if ((state_q == IDLE) && (state_d == WRITEBACK))
                wb_cnt_q <= sat_inc(wb_cnt_q);
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
    assign wb_cnt_o   = wb_cnt_q;
`endif

endmodule
